// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: checker FSM state encoding and a Gray-to-binary decode helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Contents: gray_state_e (IDLE=0, TRACK=1, FAULT=2), GRAY_MAX_W, gray2bin(g, w).
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } gray_state_e;

  // Widest code the helper can decode; callers zero-extend into this width.
  localparam int GRAY_MAX_W = 32;

  // Decodes the low w bits of g. Each binary bit is the parity of the Gray
  // bits at and above it, so a running XOR from the MSB downward gives it.
  // Bits at or above w are ignored and returned as zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int                    w);
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder, inverse of binary_to_gray.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: gray [WIDTH-1:0] in, bin [WIDTH-1:0] out. WIDTH must be 2..GRAY_MAX_W.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray), WIDTH));

endmodule

// File: rtl/gray_stream_checker.sv
// Decodes a strobed Gray-code stream and checks each sample is a +-1 (mod 2^WIDTH) step from the previous one.
// Latency: 1 cycle; all outputs are registered after the accepting edge.
// Backpressure: none; a sample may be accepted every cycle, clear drops a coincident sample.
// Ports: clk, rst_n, in_valid, in_gray, clear -> out_valid, out_bin, step_ok, step_err, dir, err_count, state.
module gray_stream_checker
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_gray,
  input  logic                 clear,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 step_ok,
  output logic                 step_err,
  output logic                 dir,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state
);

  logic [WIDTH-1:0] dec_bin;

  gray_to_binary #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray(in_gray),
    .bin (dec_bin)
  );

  gray_state_e          state_q,     state_d;
  logic [WIDTH-1:0]     prev_bin_q,  prev_bin_d;
  logic                 out_valid_q, out_valid_d;
  logic                 step_ok_q,   step_ok_d;
  logic                 step_err_q,  step_err_d;
  logic                 dir_q,       dir_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  // Unit-step tests rely on natural WIDTH-bit wraparound of the adder.
  logic is_rep, is_up, is_dn;
  assign is_rep = (dec_bin == prev_bin_q);
  assign is_up  = (dec_bin == prev_bin_q + WIDTH'(1));
  assign is_dn  = (dec_bin == prev_bin_q - WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    prev_bin_d  = prev_bin_q;
    dir_d       = dir_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = 1'b0;
    step_ok_d   = 1'b0;
    step_err_d  = 1'b0;

    if (clear) begin
      state_d    = ST_IDLE;
      prev_bin_d = '0;
      dir_d      = 1'b0;
      err_cnt_d  = '0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      // The reference always follows the stream, so one bad sample produces
      // one error rather than poisoning every sample after it.
      prev_bin_d  = dec_bin;
      unique case (state_q)
        ST_TRACK, ST_FAULT: begin
          if (is_rep) begin
            // Repeat: report the sample, leave direction and state alone.
          end else if (is_up || is_dn) begin
            step_ok_d = 1'b1;
            dir_d     = is_up;
            state_d   = ST_TRACK;
          end else begin
            step_err_d = 1'b1;
            state_d    = ST_FAULT;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          // IDLE (or an unreachable encoding): this sample is only a reference load.
          state_d = ST_TRACK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prev_bin_q  <= '0;
      out_valid_q <= 1'b0;
      step_ok_q   <= 1'b0;
      step_err_q  <= 1'b0;
      dir_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_bin_q  <= prev_bin_d;
      out_valid_q <= out_valid_d;
      step_ok_q   <= step_ok_d;
      step_err_q  <= step_err_d;
      dir_q       <= dir_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // The stored reference is by construction the latest decoded sample.
  assign out_bin   = prev_bin_q;
  assign out_valid = out_valid_q;
  assign step_ok   = step_ok_q;
  assign step_err  = step_err_q;
  assign dir       = dir_q;
  assign err_count = err_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_gray_stream_checker.sv
module tb_gray_stream_checker;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_gray;
  logic          clear;
  logic          out_valid;
  logic [W-1:0]  out_bin;
  logic          step_ok;
  logic          step_err;
  logic          dir;
  logic [CW-1:0] err_count;
  logic [1:0]    state;

  gray_stream_checker #(
    .WIDTH    (W),
    .ERR_CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_gray  (in_gray),
    .clear    (clear),
    .out_valid(out_valid),
    .out_bin  (out_bin),
    .step_ok  (step_ok),
    .step_err (step_err),
    .dir      (dir),
    .err_count(err_count),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          ov;
    logic [W-1:0]  bin;
    logic          ok;
    logic          err;
    logic          dir;
    logic [CW-1:0] cnt;
    logic [1:0]    st;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks;
  int   n_errors;
  bit   done;

  // Reference model: integer bookkeeping straight from the stream rules.
  int m_state;  // 0 idle, 1 track, 2 fault
  int m_prev;
  int m_dir;
  int m_cnt;

  localparam int MOD     = 1 << W;
  localparam int CNT_MAX = (1 << CW) - 1;

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) & (MOD - 1);
  endfunction

  function automatic int from_gray(int g);
    int b;
    b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b & (MOD - 1);
  endfunction

  function automatic obs_t pack_obs(int ov, int ok, int err);
    obs_t o;
    o.ov  = ov[0];
    o.bin = W'(m_prev);
    o.ok  = ok[0];
    o.err = err[0];
    o.dir = m_dir[0];
    o.cnt = CW'(m_cnt);
    o.st  = 2'(m_state);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.ov  = out_valid;
    o.bin = out_bin;
    o.ok  = step_ok;
    o.err = step_err;
    o.dir = dir;
    o.cnt = err_count;
    o.st  = state;
    return o;
  endfunction

  // Advances the model by one clock given this cycle's inputs, returns the expected outputs.
  function automatic obs_t model_step(bit r, bit v, bit c, int g);
    int b, diff, ok, err, ov;
    ok = 0; err = 0; ov = 0;
    if (!r) begin
      m_state = 0; m_prev = 0; m_dir = 0; m_cnt = 0;
    end else if (c) begin
      m_state = 0; m_prev = 0; m_dir = 0; m_cnt = 0;
    end else if (v) begin
      ov = 1;
      b  = from_gray(g);
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        diff = (b - m_prev + MOD) % MOD;
        if (diff == 0) begin
        end else if (diff == 1) begin
          ok = 1; m_dir = 1; m_state = 1;
        end else if (diff == MOD - 1) begin
          ok = 1; m_dir = 0; m_state = 1;
        end else begin
          err = 1; m_state = 2;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
      end
      m_prev = b;
    end
    return pack_obs(ov, ok, err);
  endfunction

  // Drives one cycle of stimulus (called away from the rising edge) and queues its expectation.
  task automatic drive(input bit r, input bit v, input bit c, input int b);
    obs_t e;
    rst_n    = r;
    in_valid = v;
    clear    = c;
    in_gray  = W'(to_gray(b));
    e = model_step(r, v, c, to_gray(b));
    exp_q.push_back(e);
    if (!r) begin
      // Reset is asynchronous: outputs must already be cleared before any edge.
      #1;
      n_checks++;
      if (dut_obs() !== e) begin
        n_errors++;
        $display("FAIL async_reset t=%0t act=%h exp=%h", $time, dut_obs(), e);
      end
    end
    @(negedge clk);
  endtask

  task automatic sample(input int b);
    drive(1'b1, 1'b1, 1'b0, b);
  endtask

  // Monitor: compares the registered outputs after every rising edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!done) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_empty t=%0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        a = dut_obs();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t act(ov,bin,ok,err,dir,cnt,st)=%b,%h,%b,%b,%b,%0d,%0d exp=%b,%h,%b,%b,%b,%0d,%0d",
                   $time, a.ov, a.bin, a.ok, a.err, a.dir, a.cnt, a.st,
                   e.ov, e.bin, e.ok, e.err, e.dir, e.cnt, e.st);
        end
        if (step_ok && step_err) begin
          n_errors++;
          $display("FAIL ok_and_err t=%0t act=both exp=exclusive", $time);
        end
      end
    end
  end

  initial begin
    int b, kind;
    n_checks = 0; n_errors = 0; done = 1'b0;
    m_state = 0; m_prev = 0; m_dir = 0; m_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; in_gray = '0;

    // Reset, then release.
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 5);
    drive(1'b1, 1'b0, 1'b0, 0);

    // Ascending 0..15 and wrap to 0.
    for (int i = 0; i <= 16; i++) sample(i % 16);
    // Descending from 0 through the wrap: 0,15,14,...,10.
    for (int i = 0; i <= 6; i++) sample((16 - i) % 16);
    drive(1'b1, 1'b0, 1'b0, 0);

    // Walk to bin 3, legal 4, illegal 6, recovery 7.
    for (int i = 9; i >= 3; i--) sample(i);
    sample(4);
    sample(6);
    sample(7);

    // Five consecutive illegal jumps: counter saturates.
    sample(9); sample(11); sample(13); sample(15); sample(1);
    // Legal back to bin 2 (gray 0011), then repeat it.
    sample(2);
    sample(2);
    drive(1'b1, 1'b0, 1'b0, 0);

    // Clear wins over a coincident sample, then a fresh IDLE load.
    drive(1'b1, 1'b1, 1'b1, 8);
    drive(1'b1, 1'b0, 1'b0, 0);
    sample(5);
    sample(6);
    sample(8);
    // Reset mid-stream with a sample present, release, IDLE load.
    drive(1'b0, 1'b1, 1'b0, 7);
    drive(1'b1, 1'b1, 1'b0, 9);
    sample(10);
    sample(9);

    // Randomised traffic: mostly legal steps, some repeats, jumps, idles, clears and resets.
    b = m_prev;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(99);
      if (kind < 2) begin
        drive(1'b0, $urandom_range(1), 1'b0, $urandom_range(MOD - 1));
      end else if (kind < 5) begin
        drive(1'b1, $urandom_range(1), 1'b1, $urandom_range(MOD - 1));
      end else if (kind < 20) begin
        drive(1'b1, 1'b0, 1'b0, $urandom_range(MOD - 1));
      end else begin
        if (kind < 50)      b = (m_prev + 1) % MOD;
        else if (kind < 75) b = (m_prev + MOD - 1) % MOD;
        else if (kind < 83) b = m_prev;
        else                b = $urandom_range(MOD - 1);
        sample(b);
      end
    end

    drive(1'b1, 1'b0, 1'b0, 0);
    done = 1'b1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain act=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_stream_checker.md
# gray_stream_checker

Downstream consumer of the binary-to-Gray converter output. Accepts a strobed stream of WIDTH-bit Gray codes, decodes each to binary, and checks that consecutive codes form a legal unit step (±1 modulo 2^WIDTH). Reports direction, per-sample step status and a saturating error count, so counter/encoder paths built on Gray coding can be monitored in-system and in simulation.

## Interface
- WIDTH, 4: Gray/binary code width; minimum 2.
- ERR_CNT_W, 8: error counter width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_gray is sampled on this clock edge.
- in_gray  input  WIDTH  Gray code sample.
- clear  input  1  synchronous clear; returns to IDLE and zeroes the counter.
- out_valid  output  1  one-cycle pulse; out_bin and status belong to the latest accepted sample.
- out_bin  output  WIDTH  decoded binary value of the latest sample; held between samples.
- step_ok  output  1  pulse with out_valid; legal ±1 step.
- step_err  output  1  pulse with out_valid; illegal transition.
- dir  output  1  1 = last legal step was up, 0 = down; held.
- err_count  output  ERR_CNT_W  illegal transitions since reset/clear; saturates at all-ones.
- state  output  2  IDLE=0, TRACK=1, FAULT=2.

## Operation
- Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i] for i from WIDTH-2 down to 0.
- Stored reference prev_bin is updated to the decoded value on every accepted sample, legal or not.
- Step classification against prev_bin, arithmetic modulo 2^WIDTH:
  - equal: repeat; out_valid=1, step_ok=0, step_err=0, dir unchanged, no state change.
  - prev+1: step_ok=1, dir=1. Includes wrap all-ones → 0.
  - prev-1: step_ok=1, dir=0. Includes wrap 0 → all-ones.
  - anything else: step_err=1, err_count+1 (saturating), dir unchanged.
- FSM:
  - IDLE: first accepted sample loads prev_bin, out_valid=1, no step pulse → TRACK.
  - TRACK: illegal step → FAULT; otherwise stay.
  - FAULT: legal step → TRACK; illegal step → stay in FAULT and increment again; repeat → stay in FAULT.
- clear: state→IDLE, err_count→0, dir→0, out_bin→0, prev_bin→0, no pulses. clear with in_valid in the same cycle: clear wins; the sample is dropped.
- step_ok and step_err are never high together, and never high without out_valid.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_bin=0, step_ok=0, step_err=0, dir=0, err_count=0, state=IDLE, prev_bin=0.
- Latency 1: a sample accepted at edge k sets out_valid, out_bin, step_ok/step_err, dir, err_count and state as registered outputs after edge k. Pulses drop after edge k+1 unless another sample is accepted at k+1.
- Back-to-back in_valid every cycle is supported at full rate with no stalls.
- Reset asserted mid-stream clears all state immediately; the first sample after release is treated as an IDLE load.

## Structure
- Shared package gray_pkg: state enum (IDLE/TRACK/FAULT, 2-bit) and gray2bin function parameterised by width. The binary-to-Gray converter reuses the same package.
- One sub-module: gray_to_binary (combinational, WIDTH parameter), the inverse of binary_to_gray. The checker instantiates it on in_gray.
- Top: FSM, prev_bin register, modular ±1 compare, saturating counter.

## Test plan
- Reset then feed Gray 0→15 (0000,0001,0011,…,1000) and wrap to 0000 → first sample gives out_valid with no step pulse; the next 16 give step_ok=1, dir=1, out_bin=1..15,0; err_count=0; state=TRACK.
- Descending sequence 0000→1000 (bin 0→15) then 1001 (bin 14) → step_ok=1, dir=0 on each sample, including the wrap.
- In TRACK at bin 3 (0010), inject 0110 (bin 4, legal) then 0101 (bin 6) → step_err=1, err_count=1, state=FAULT. Then 0100 (bin 7) → step_ok, state=TRACK.
- ERR_CNT_W=2: drive 5 consecutive illegal jumps → err_count sticks at 3 and state stays FAULT.
- Repeat sample 0011 twice → second gives out_valid=1, step_ok=0, step_err=0, dir unchanged.
- Assert clear together with in_valid, then pull rst_n low mid-stream → after clear: state=IDLE, err_count=0, no pulse for the dropped sample. After reset: all outputs 0, and the next sample is an IDLE load.
